pc_next_unit: RTL and testbench
===============================

Name: pc_next_unit

Overview:
- Program-counter register and next-PC selector for the MIPS single-cycle datapath.
- Consumes the word-aligned branch offset produced by the shift-left-by-2 stage and the 26-bit jump index from the instruction word.
- Selects the next PC from sequential, branch, jump and jump-register sources, and supports stalls.
- Traps misaligned jump-register targets into a halted state and counts retired instructions.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word aligned.
- COUNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  advance enable; 0 = stall, and all state holds.
- branch_taken  input  1  conditional branch resolved taken this cycle.
- branch_offset_sl2  input  32  sign-extended immediate, already shifted left 2.
- jump  input  1  J/JAL in flight.
- jump_index  input  26  instr[25:0].
- jump_reg  input  1  JR/JALR in flight.
- jr_target  input  32  register-file value for JR.
- pc  output  32  current PC, registered.
- pc_plus4  output  32  pc + 4, combinational from pc.
- halted  output  1  1 while in HALT state.
- fault_addr  output  32  offending JR target captured on fault.
- retired_count  output  COUNT_W  instructions retired since reset.

Behaviour:
- Reset (async, any time, including mid-stall or in HALT):
  - pc = RESET_PC, state = RUN, halted = 0, fault_addr = 0, retired_count = 0.
  - Takes effect immediately, without waiting for a clock edge.
- Arithmetic: all 32-bit, modulo 2^32, no overflow detection.
  - pc_plus4 = pc + 4.
  - Branch target = pc_plus4 + branch_offset_sl2.
  - Jump target = {pc_plus4[31:28], jump_index, 2'b00}.
- Next-PC priority when selecting a source: jump_reg > jump > branch_taken > pc_plus4.
  - Multiple selects asserted together resolve by this priority; no error is raised.
- State RUN, on each clock edge with en = 1:
  - If jump_reg = 1 and jr_target[1:0] != 0:
    - fault_addr <= jr_target and state <= HALT.
    - pc holds; retired_count does not increment.
  - Otherwise:
    - pc <= selected next PC.
    - retired_count <= retired_count + 1, wrapping to 0 after all-ones.
- State RUN, en = 0: pc, retired_count and fault_addr hold. Inputs are ignored, including a misaligned jr_target.
- State HALT:
  - halted = 1; pc, fault_addr and retired_count frozen.
  - All inputs, including en, are ignored.
  - The only exit is reset.
- Latency: a selection made in cycle N appears on pc after the rising edge that ends cycle N; this is one-cycle registered latency.
- A misaligned branch or jump target cannot occur, because offsets are pre-shifted; no check is made on those paths.
- A misaligned jr_target when jump_reg = 0 is ignored.
- halted is a registered output (decode of state).
- No X propagation from unselected sources: e.g. a jr_target of X with jump_reg = 0 must not corrupt pc.

Test Plan:
1. Sequential run: reset with RESET_PC = 0, en = 1, no selects, 4 clocks -> pc = 0x10, retired_count = 4, halted = 0.
2. Branch: pc = 0x0000_0100, branch_taken = 1, branch_offset_sl2 = 0xFFFF_FFF0 -> next pc = 0x0000_00F4.
   - Repeat with offset 0x0000_0020 -> next pc = 0x0000_0124.
3. Jump and priority:
   - pc = 0x4000_0000, jump = 1, jump_index = 0x0000_040 -> next pc = 0x4000_0100.
   - Then jump = 1, branch_taken = 1, jump_reg = 1, jr_target = 0x0000_2000 -> next pc = 0x0000_2000.
4. Stall: en = 0 for 3 cycles with branch_taken = 1 -> pc and retired_count unchanged; pc advances on the first cycle after en returns to 1.
5. JR fault: jump_reg = 1, jr_target = 0x0000_1002, en = 1 -> halted = 1, fault_addr = 0x0000_1002, pc unchanged.
   - 5 further clocks with en = 1 and varied selects -> pc and retired_count frozen.
6. Async reset and wrap:
   - Assert reset mid-cycle while halted -> pc = RESET_PC and halted = 0 before the next edge.
   - With COUNT_W = 3, 9 advances -> retired_count = 1.

Source files
------------

// File: rtl/pc_next_if.sv
// pc_next_if: control inputs and PC/status outputs of the next-PC unit
interface pc_next_if #(parameter int COUNT_W = 32);
  logic               en;
  logic               branch_taken;
  logic [31:0]        branch_offset_sl2;
  logic               jump;
  logic [25:0]        jump_index;
  logic               jump_reg;
  logic [31:0]        jr_target;
  logic [31:0]        pc;
  logic [31:0]        pc_plus4;
  logic               halted;
  logic [31:0]        fault_addr;
  logic [COUNT_W-1:0] retired_count;
  modport master (
    output en, branch_taken, branch_offset_sl2, jump, jump_index, jump_reg, jr_target,
    input  pc, pc_plus4, halted, fault_addr, retired_count
  );
  modport slave (
    input  en, branch_taken, branch_offset_sl2, jump, jump_index, jump_reg, jr_target,
    output pc, pc_plus4, halted, fault_addr, retired_count
  );
endinterface

// File: rtl/pc_next_unit.sv
// pc_next_unit: PC register, next-PC select, JR alignment trap and retired counter
module pc_next_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          COUNT_W  = 32
) (
  input logic       clk,
  input logic       reset,
  pc_next_if.slave  bus
);
  typedef enum logic {RUN, HALT} state_t;
  state_t             state, state_nx;
  logic [31:0]        pc_nx, fault_nx;
  logic [COUNT_W-1:0] cnt_nx;
  logic               misaligned;
  assign bus.pc_plus4 = bus.pc + 32'd4;
  // unselected sources are gated by the selects so an X jr_target cannot leak in
  assign misaligned = bus.jump_reg && (bus.jr_target[1:0] != 2'b00);
  always_comb begin
    state_nx = state;
    pc_nx    = bus.pc;
    fault_nx = bus.fault_addr;
    cnt_nx   = bus.retired_count;
    if (state == RUN && bus.en) begin
      if (misaligned) begin
        state_nx = HALT;
        fault_nx = bus.jr_target;
      end else begin
        pc_nx  = bus.jump_reg     ? bus.jr_target :
                 bus.jump         ? {bus.pc_plus4[31:28], bus.jump_index, 2'b00} :
                 bus.branch_taken ? bus.pc_plus4 + bus.branch_offset_sl2 :
                                    bus.pc_plus4;
        cnt_nx = bus.retired_count + COUNT_W'(1);
      end
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= RUN;
      bus.pc            <= RESET_PC;
      bus.fault_addr    <= 32'd0;
      bus.retired_count <= '0;
      bus.halted        <= 1'b0;
    end else begin
      state             <= state_nx;
      bus.pc            <= pc_nx;
      bus.fault_addr    <= fault_nx;
      bus.retired_count <= cnt_nx;
      bus.halted        <= (state_nx == HALT);
    end
  end
endmodule

// File: tb/tb_pc_next_unit.sv
// tb_pc_next_unit: directed plan plus random stimulus against a behavioural PC model
module tb_pc_next_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic        en, br, jmp, jr;
  logic [31:0] off, jrt;
  logic [25:0] idx;
  logic [31:0] m_pc, m_fault, m_cnt;
  logic        m_halt;
  int          n_chk = 0, n_err = 0;
  always #5 clk = ~clk;
  pc_next_if #(.COUNT_W(32)) bus();
  pc_next_if #(.COUNT_W(3))  bus_w();
  assign bus.en = en;                  assign bus_w.en = en;
  assign bus.branch_taken = br;        assign bus_w.branch_taken = br;
  assign bus.branch_offset_sl2 = off;  assign bus_w.branch_offset_sl2 = off;
  assign bus.jump = jmp;               assign bus_w.jump = jmp;
  assign bus.jump_index = idx;         assign bus_w.jump_index = idx;
  assign bus.jump_reg = jr;            assign bus_w.jump_reg = jr;
  assign bus.jr_target = jrt;          assign bus_w.jr_target = jrt;
  pc_next_unit #(.RESET_PC(32'h0), .COUNT_W(32)) dut   (.clk(clk), .reset(reset), .bus(bus.slave));
  pc_next_unit #(.RESET_PC(32'h0), .COUNT_W(3))  dut_w (.clk(clk), .reset(reset), .bus(bus_w.slave));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic check_all();
    chk("pc", bus.pc, m_pc);
    chk("pc_plus4", bus.pc_plus4, m_pc + 32'd4);
    chk("halted", {31'd0, bus.halted}, {31'd0, m_halt});
    chk("fault_addr", bus.fault_addr, m_fault);
    chk("retired", bus.retired_count, m_cnt);
    chk("retired_w3", {29'd0, bus_w.retired_count}, m_cnt % 8);
    chk("pc_w3", bus_w.pc, m_pc);
  endtask
  task automatic model_reset();
    m_pc = 32'h0; m_fault = 32'h0; m_cnt = 32'h0; m_halt = 1'b0;
  endtask
  task automatic model_step();
    logic [31:0] p4;
    p4 = m_pc + 32'd4;
    if (!m_halt && en === 1'b1) begin
      if (jr && jrt[1:0] != 2'b00) begin
        m_fault = jrt;
        m_halt  = 1'b1;
      end else begin
        if (jr)       m_pc = jrt;
        else if (jmp) m_pc = {p4[31:28], idx, 2'b00};
        else if (br)  m_pc = p4 + off;
        else          m_pc = p4;
        m_cnt = m_cnt + 1;
      end
    end
  endtask
  task automatic step();
    @(posedge clk);
    model_step();
    #1 check_all();
  endtask
  task automatic set_in(input logic e, input logic b, input logic [31:0] o, input logic j,
                        input logic [25:0] i, input logic r, input logic [31:0] t);
    en = e; br = b; off = o; jmp = j; idx = i; jr = r; jrt = t;
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    #1 check_all();
    @(negedge clk);
    reset = 1'b0;
  endtask
  initial begin
    reset = 1'b0;
    set_in(1, 0, 0, 0, 0, 0, 0);
    do_reset();
    for (int i = 0; i < 4; i++) step();
    chk("seq_pc", bus.pc, 32'h10);
    chk("seq_cnt", bus.retired_count, 32'd4);
    set_in(1, 0, 0, 0, 0, 1, 32'h100);         step();
    set_in(1, 1, 32'hFFFF_FFF0, 0, 0, 0, 0);   step();
    chk("br_back", bus.pc, 32'h0000_00F4);
    set_in(1, 0, 0, 0, 0, 1, 32'h100);         step();
    set_in(1, 1, 32'h20, 0, 0, 0, 0);          step();
    chk("br_fwd", bus.pc, 32'h0000_0124);
    set_in(1, 0, 0, 0, 0, 1, 32'h4000_0000);   step();
    set_in(1, 0, 0, 1, 26'h40, 0, 0);          step();
    chk("jump", bus.pc, 32'h4000_0100);
    set_in(1, 1, 32'h80, 1, 26'h123, 1, 32'h2000); step();
    chk("priority", bus.pc, 32'h0000_2000);
    set_in(0, 1, 32'h40, 0, 0, 0, 32'h3);      step();
    set_in(0, 1, 32'h40, 0, 0, 1, 32'h3);      step();
    set_in(0, 1, 32'h40, 0, 0, 0, 32'h3);      step();
    chk("stall_pc", bus.pc, 32'h2000);
    chk("stall_halt", {31'd0, bus.halted}, 32'd0);
    set_in(1, 1, 32'h40, 0, 0, 0, 32'h3);      step();
    chk("unstall", bus.pc, 32'h2044);
    set_in(1, 0, 0, 0, 0, 0, 'x);              step();
    chk("x_jrt", bus.pc, 32'h2048);
    set_in(1, 0, 0, 0, 0, 1, 32'h1002);        step();
    chk("fault_halt", {31'd0, bus.halted}, 32'd1);
    chk("fault_addr_d", bus.fault_addr, 32'h1002);
    chk("fault_pc", bus.pc, 32'h2048);
    for (int i = 0; i < 5; i++) begin
      set_in(1, $urandom_range(0, 1), $urandom, $urandom_range(0, 1), 26'($urandom),
             $urandom_range(0, 1), {$urandom, 2'b00} >> 2);
      step();
    end
    chk("frozen_pc", bus.pc, 32'h2048);
    @(posedge clk);
    model_step();
    #2 reset = 1'b1;
    model_reset();
    #1 check_all();
    chk("async_halt", {31'd0, bus.halted}, 32'd0);
    #1 reset = 1'b0;
    set_in(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) step();
    chk("wrap_w3", {29'd0, bus_w.retired_count}, 32'd1);
    for (int i = 0; i < 400; i++) begin
      logic [31:0] r;
      if (m_halt && $urandom_range(0, 3) == 0) do_reset();
      r = $urandom;
      set_in($urandom_range(0, 4) != 0, $urandom_range(0, 2) == 0, $urandom, $urandom_range(0, 3) == 0,
             26'($urandom), $urandom_range(0, 4) == 0,
             ($urandom_range(0, 9) == 0) ? r : {r[31:2], 2'b00});
      step();
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
